// File: rtl/prim_sky130_ram_arb.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Handshake: an access completes in any cycle where req_i[p] && gnt_o[p].
// A port that is not granted keeps req/addr/data stable until it is granted,
// because nothing is queued here. Every completed access gets exactly one
// rvalid_o[p] pulse on the following cycle. rdata_o and err_o are only
// meaningful in that cycle and are driven to 0 at all other times.
module prim_sky130_ram_arb #(
  parameter int Width = 32,
  parameter int Depth = 512,
  localparam int Aw = $clog2(Depth)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 write_i,
  input  logic [1:0][Aw-1:0]         addr_i,
  input  logic [1:0][Width-1:0]      wdata_i,
  input  logic [1:0][Width-1:0]      wmask_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 rvalid_o,
  output logic [Width-1:0]           rdata_o,
  output logic [1:0]                 err_o,
  output logic                       mem_req_o,
  output logic                       mem_write_o,
  output logic [Aw-1:0]              mem_addr_o,
  output logic [Width-1:0]           mem_wdata_o,
  output logic [Width-1:0]           mem_wmask_o,
  input  logic [Width-1:0]           mem_rdata_i
);

  localparam int Lanes = Width / 8;

  // Port that won the most recent grant. It loses the next conflict.
  logic             r_last_q;
  // One-deep response stage: owner, type, error and valid of the access in flight.
  logic             r_rsp_valid;
  logic             r_rsp_port;
  logic             r_rsp_read;
  logic             r_rsp_err;

  logic [1:0]       w_gnt;
  logic             w_gnt_port;
  logic             w_partial;
  logic             w_mem_write;
  logic [Aw-1:0]    w_mem_addr;
  logic [Width-1:0] w_mem_wdata;
  logic [Width-1:0] w_mem_wmask;

  // Grant selection: a lone requester wins at once, a conflict goes to the
  // port that did not win last time. Grants are suppressed while in reset.
  always_comb begin
    w_gnt = 2'b00;
    if (rst_ni) begin
      if (req_i == 2'b11) begin
        w_gnt = r_last_q ? 2'b01 : 2'b10;
      end else begin
        w_gnt = req_i;
      end
    end
  end

  assign w_gnt_port = w_gnt[1];

  // Route the granted port's command to the RAM; all zero when idle.
  always_comb begin
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_wmask = '0;
    if (w_gnt != 2'b00) begin
      w_mem_write = write_i[w_gnt_port];
      w_mem_addr  = addr_i[w_gnt_port];
      w_mem_wdata = wdata_i[w_gnt_port];
      w_mem_wmask = wmask_i[w_gnt_port];
    end
  end

  // A byte lane whose mask is neither all-0 nor all-1 flags a partial write.
  always_comb begin
    w_partial = 1'b0;
    for (int b = 0; b < Lanes; b++) begin
      if ((w_mem_wmask[8*b +: 8] != 8'h00) && (w_mem_wmask[8*b +: 8] != 8'hFF)) begin
        w_partial = 1'b1;
      end
    end
  end

  // Round-robin pointer: follows the granted port, holds when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_q <= 1'b1;
    end else if (w_gnt != 2'b00) begin
      r_last_q <= w_gnt_port;
    end
  end

  // Response stage: capture who was granted and what kind of access it was.
  // Reset clears the valid bit, which cancels any response still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_port  <= 1'b0;
      r_rsp_read  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= (w_gnt != 2'b00);
      r_rsp_port  <= w_gnt_port;
      r_rsp_read  <= (w_gnt != 2'b00) && !w_mem_write;
      r_rsp_err   <= (w_gnt != 2'b00) && w_mem_write && w_partial;
    end
  end

  assign gnt_o       = w_gnt;
  assign mem_req_o   = (w_gnt != 2'b00);
  assign mem_write_o = w_mem_write;
  assign mem_addr_o  = w_mem_addr;
  assign mem_wdata_o = w_mem_wdata;
  assign mem_wmask_o = w_mem_wmask;

  assign rvalid_o = {r_rsp_valid & r_rsp_port, r_rsp_valid & ~r_rsp_port};
  assign err_o    = {r_rsp_valid & r_rsp_err & r_rsp_port,
                     r_rsp_valid & r_rsp_err & ~r_rsp_port};
  assign rdata_o  = (r_rsp_valid && r_rsp_read) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_prim_sky130_ram_arb.sv
// Bench for prim_sky130_ram_arb: a behavioural RAM on the memory side, a
// reference model of arbitration and memory contents, and a response monitor
// that pops an expected queue whenever the DUT presents rvalid_o.
module tb_prim_sky130_ram_arb;

  localparam int Width = 32;
  localparam int Depth = 512;
  localparam int Aw    = 9;
  localparam int EW    = 16 + 1 + 1 + 32;  // {due cycle, port, err, rdata}

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc = cyc + 1;

  // ---------------- DUT ----------------
  logic [1:0]            req_i;
  logic [1:0]            write_i;
  logic [1:0][Aw-1:0]    addr_i;
  logic [1:0][Width-1:0] wdata_i;
  logic [1:0][Width-1:0] wmask_i;
  logic [1:0]            gnt_o;
  logic [1:0]            rvalid_o;
  logic [Width-1:0]      rdata_o;
  logic [1:0]            err_o;
  logic                  mem_req_o;
  logic                  mem_write_o;
  logic [Aw-1:0]         mem_addr_o;
  logic [Width-1:0]      mem_wdata_o;
  logic [Width-1:0]      mem_wmask_o;
  logic [Width-1:0]      mem_rdata_i;

  prim_sky130_ram_arb #(.Width(Width), .Depth(Depth)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .wmask_i     (wmask_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wmask_o (mem_wmask_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // ---------------- behavioural single-port RAM ----------------
  logic [Width-1:0] ram [Depth];
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_write_o) ram[mem_addr_o] <= (ram[mem_addr_o] & ~mem_wmask_o) | (mem_wdata_o & mem_wmask_o);
      else             mem_rdata_i <= ram[mem_addr_o];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [Width-1:0] ref_mem [Depth];
  int               m_last;          // port that won the last grant
  logic [EW-1:0]    exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Which port should win given the current requests and who won last.
  function automatic int model_winner(input logic [1:0] req, input int last);
    if (req == 2'b00) return -1;
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return 1 - last;
  endfunction

  // True when some byte of the mask is partially set.
  function automatic bit model_partial(input logic [Width-1:0] mask);
    for (int b = 0; b < Width / 8; b++) begin
      int unsigned v;
      v = (mask >> (8 * b)) & 32'hFF;
      if (v != 0 && v != 255) return 1'b1;
    end
    return 1'b0;
  endfunction

  int last_winner;  // winner in the most recent checked cycle, -1 for none

  // Check the combinational grant and RAM command for the current inputs,
  // then record the expected response and update the model.
  task automatic check_and_push();
    int p;
    logic [Width-1:0] ed;
    bit e_err;
    #1;
    p = model_winner(req_i, m_last);
    last_winner = p;
    if (p < 0) begin
      chk("gnt_idle", gnt_o, 2'b00);
      chk("mem_idle", {mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o}, '0);
      chk("mem_wmask_idle", mem_wmask_o, '0);
    end else begin
      chk("gnt", gnt_o, (p == 1) ? 2'b10 : 2'b01);
      chk("mem_cmd", {mem_req_o, mem_write_o, mem_addr_o}, {1'b1, write_i[p], addr_i[p]});
      chk("mem_wdata", mem_wdata_o, wdata_i[p]);
      chk("mem_wmask", mem_wmask_o, wmask_i[p]);
      e_err = write_i[p] && model_partial(wmask_i[p]);
      ed = write_i[p] ? '0 : ref_mem[addr_i[p]];
      if (write_i[p]) ref_mem[addr_i[p]] = (ref_mem[addr_i[p]] & ~wmask_i[p]) | (wdata_i[p] & wmask_i[p]);
      exp_q.push_back({16'(cyc + 1), 1'(p), e_err, ed});
      m_last = p;
    end
  endtask

  task automatic step();
    check_and_push();
    @(negedge clk_i);
  endtask

  // Short reset pulse between edges; requests drop so nothing new is granted.
  task automatic reset_pulse();
    #1;
    rst_ni = 1'b0;
    req_i  = 2'b11;
    #1;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_rvalid", {rvalid_o, err_o}, 4'b0);
    req_i = 2'b00;
    exp_q.delete();
    m_last = 1;
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic set_port(input int p, input bit rq, input bit wr, input logic [Aw-1:0] a,
                          input logic [Width-1:0] d, input logic [Width-1:0] m);
    req_i[p]   = rq;
    write_i[p] = wr;
    addr_i[p]  = a;
    wdata_i[p] = d;
    wmask_i[p] = m;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rvalid_o != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", rvalid_o, 2'b00);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(e[49:34]));
          chk("rvalid", rvalid_o, e[33] ? 2'b10 : 2'b01);
          chk("err", err_o, e[32] ? (e[33] ? 2'b10 : 2'b01) : 2'b00);
          chk("rdata", rdata_o, e[31:0]);
        end
      end else begin
        chk("idle_rsp", {err_o, rdata_o}, '0);
        if (exp_q.size() != 0 && exp_q[0][49:34] <= 16'(cyc)) begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("missing_rvalid", rvalid_o, e[33] ? 2'b10 : 2'b01);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit hold [2];
    for (int i = 0; i < Depth; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    m_last  = 1;
    rst_ni  = 1'b0;
    req_i   = 2'b11;
    write_i = '0;
    addr_i  = '0;
    wdata_i = '0;
    wmask_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("reset_gnt", gnt_o, 2'b00);
    chk("reset_out", {rvalid_o, err_o, mem_req_o}, '0);
    req_i  = 2'b00;
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Port 0 write then port 1 read of the same word.
    set_port(0, 1, 1, 9'd5, 32'hDEADBEEF, 32'hFFFF_FFFF);
    step();
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 1, 0, 9'd5, 0, 0);
    step();
    set_port(1, 0, 0, 0, 0, 0);
    step();
    step();

    // Both ports request continuously after reset: strict alternation from port 0.
    reset_pulse();
    set_port(0, 1, 0, 9'd5, 0, 0);
    set_port(1, 1, 1, 9'd7, 32'h1234_5678, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      check_and_push();
      chk("alt_grant", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk_i);
    end
    req_i = 2'b00;
    step();
    step();

    // Partial-lane mask flags an error; whole-lane mask does not.
    set_port(1, 1, 1, 9'd20, 32'hA5A5_A5A5, 32'h0000_00F0);
    step();
    set_port(1, 1, 1, 9'd21, 32'h5A5A_5A5A, 32'hFF00_00FF);
    step();
    set_port(1, 1, 0, 9'd20, 0, 0);
    step();
    req_i = 2'b00;
    step();
    step();

    // Read granted then reset pulse before the response edge.
    set_port(0, 1, 0, 9'd5, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    check_and_push();
    reset_pulse();
    set_port(0, 1, 0, 9'd7, 0, 0);
    set_port(1, 1, 0, 9'd5, 0, 0);
    check_and_push();
    chk("post_reset_conflict", gnt_o, 2'b01);
    @(negedge clk_i);
    req_i = 2'b00;
    step();
    step();

    // Port 0 alone for 4 cycles, then a conflict should go to port 1.
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1, 0, 9'(i), 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      step();
    end
    set_port(0, 1, 0, 9'd1, 0, 0);
    set_port(1, 1, 0, 9'd2, 0, 0);
    check_and_push();
    chk("after_solo_conflict", gnt_o, 2'b10);
    @(negedge clk_i);
    req_i = 2'b00;
    step();

    // Randomized traffic; a port that lost keeps its request stable.
    hold[0] = 0;
    hold[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
        hold[0] = 0;
        hold[1] = 0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          logic [Width-1:0] m;
          case ($urandom_range(0, 3))
            0: m = 32'hFFFF_FFFF;
            1: m = {{8{$urandom_range(0, 1) == 1}}, {8{$urandom_range(0, 1) == 1}},
                    {8{$urandom_range(0, 1) == 1}}, {8{$urandom_range(0, 1) == 1}}};
            default: m = $urandom;
          endcase
          set_port(p, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   9'($urandom_range(0, 15)), $urandom, m);
        end
      end
      check_and_push();
      for (int p = 0; p < 2; p++) hold[p] = req_i[p] && (last_winner != p);
      @(negedge clk_i);
    end

    req_i = 2'b00;
    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prim_sky130_ram_arb.md
PRIM_SKY130_RAM_ARB -- requirements
Module: prim_sky130_ram_arb

Interface
REQ-001 SHALL have parameter Width, default 32, data width in bits; only 32 supported.
REQ-002 SHALL have parameter Depth, default 512, words; only 512 supported.
REQ-003 SHALL derive localparam Aw = $clog2(Depth) (9).
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_i  input  [1:0]  per-port access request.
REQ-007 write_i  input  [1:0]  per-port write (1) / read (0).
REQ-008 addr_i  input  [1:0][Aw-1:0]  per-port word address.
REQ-009 wdata_i  input  [1:0][Width-1:0]  per-port write data.
REQ-010 wmask_i  input  [1:0][Width-1:0]  per-port bit write mask.
REQ-011 gnt_o  output  [1:0]  per-port grant, combinational.
REQ-012 rvalid_o  output  [1:0]  per-port response valid.
REQ-013 rdata_o  output  [Width-1:0]  shared read data, qualified by rvalid_o.
REQ-014 err_o  output  [1:0]  per-port partial-byte-mask write error, qualified by rvalid_o.
REQ-015 mem_req_o, mem_write_o  output  1 each  to single-port RAM.
REQ-016 mem_addr_o  output  Aw; mem_wdata_o, mem_wmask_o  output  Width  to RAM.
REQ-017 mem_rdata_i  input  Width  RAM read data, valid one cycle after mem_req_o.

Function
REQ-018 An access SHALL complete when req_i[p] && gnt_o[p] in the same cycle; at most one gnt_o bit high per cycle.
REQ-019 gnt_o[p] SHALL never be high when req_i[p] is low.
REQ-020 Single requester SHALL be granted the same cycle (no bubble).
REQ-021 Both requesting: grant port != last_q (round robin); last_q updates to the granted port on every grant, holds otherwise.
REQ-022 last_q SHALL reset to 1, so port 0 wins the first conflict.
REQ-023 mem_req_o = |gnt_o; mem_write_o/addr/wdata/wmask SHALL be the granted port's inputs (combinational mux); when idle mem_* data outputs SHALL be 0.
REQ-024 Per granted access, rvalid_o[p] SHALL pulse exactly one cycle later for reads and writes; rvalid_o one-hot or zero.
REQ-025 rdata_o SHALL equal mem_rdata_i in a read response cycle, 0 otherwise.
REQ-026 A write where any byte lane of wmask_i is neither all-0 nor all-1 SHALL still be issued unchanged; err_o[p] SHALL be 1 with its rvalid_o[p]; otherwise err_o = 0.
REQ-027 Back-to-back accesses every cycle SHALL be supported (throughput 1 access/cycle), including alternating ports.
REQ-028 Response owner/type/error SHALL be held in a 1-deep registered pipeline stage (port id, is_read, err, valid).
REQ-029 A port not granted SHALL be expected to hold req/addr/data stable until granted; the block SHALL not queue requests.

Reset
REQ-030 While rst_ni low: rvalid_o=0, err_o=0, response stage valid=0, last_q=1; gnt_o and mem_req_o forced 0.
REQ-031 Reset asserted mid-access SHALL cancel the pending response; no rvalid_o after reset release for pre-reset grants.
REQ-032 First grant SHALL be possible in the first cycle after rst_ni deasserts.

Verification
REQ-033 Port 0 writes 0xDEADBEEF to addr 5 (mask all-1), then port 1 reads addr 5 -> gnt same cycle each, rvalid_o=2'b01 then 2'b10, rdata_o=0xDEADBEEF, err_o=0.
REQ-034 Both ports request continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; rvalid_o follows one cycle later in same order.
REQ-035 Port 1 write with wmask_i=0x0000_00F0 -> mem_wmask_o=0x0000_00F0 passed, rvalid_o[1]=1 with err_o[1]=1 next cycle; mask 0xFF00_00FF -> err_o=0.
REQ-036 Read granted, rst_ni pulsed low before next edge -> rvalid_o stays 0, next conflict grants port 0.
REQ-037 Port 0 alone requests 4 consecutive cycles -> gnt_o[0] every cycle, 4 consecutive rvalid_o[0] pulses, last_q=0 afterwards so next conflict grants port 1.
